// File: rtl/watchdog_ctrl_pkg.sv
// watchdog_ctrl_pkg
//   Shared constants for the two-stage watchdog: IO register addresses,
//   CTRL/STATUS bit positions and the FSM state encoding.
package watchdog_ctrl_pkg;

    localparam int BUS_W = 16;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_RELOAD = 2'd1;
    localparam logic [1:0] ADDR_KICK   = 2'd2;   // write = kick, read = count
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_PRESC_LSB  = 8;

    localparam int STAT_WARN_BIT = 0;
    localparam int STAT_RST_BIT  = 1;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WARN = 2'd1,
        ST_RST  = 2'd2
    } wd_state_e;

endpackage

// File: rtl/watchdog_ctrl_if.sv
// watchdog_ctrl_if
//   Chip-selected IO bus as seen by the watchdog.
//   isCS  : chip select          isW : write strobe (qualified by isCS)
//   addr  : register select      dR  : write data (bus -> peripheral)
//   dW    : read data (peripheral -> bus), combinational
interface watchdog_ctrl_if;
    import watchdog_ctrl_pkg::*;

    logic             isCS;
    logic             isW;
    logic [1:0]       addr;
    logic [BUS_W-1:0] dR;
    logic [BUS_W-1:0] dW;

    modport master (output isCS, isW, addr, dR, input dW);
    modport slave  (input isCS, isW, addr, dR, output dW);
endinterface

// File: rtl/watchdog_ctrl_prescaler.sv
// wd_prescaler
//   Counts 0..presc while enabled and fires tick on the terminal value.
//   clk     : IO clock, state updates on the falling edge
//   isReset : synchronous active-high reset
//   en      : count enable (frozen when low)
//   clr     : restart from 0 (kick / end of reset pulse)
//   presc   : terminal value
//   tick    : combinational, high on the edge the count wraps
module wd_prescaler #(
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               isReset,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);
    logic [PRESC_W-1:0] cnt_q, cnt_d;

    // >= rather than == so that lowering PRESC below the running count
    // wraps at the next compare instead of running round the full range.
    assign tick = en && (cnt_q >= presc);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || tick) cnt_d = '0;
        else if (en)     cnt_d = cnt_q + 1'b1;
    end

    always_ff @(negedge clk) begin
        if (isReset) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
endmodule

// File: rtl/watchdog_ctrl.sv
// watchdog_ctrl
//   Two-stage watchdog: first expiry raises warn_flag (+ optional irq),
//   second expiry without a kick drives a RST_PULSE-cycle system reset.
//   clk     : IO clock, all state updates on the falling edge
//   isReset : synchronous active-high reset, highest priority
//   bus     : IO register port (CTRL, RELOAD, KICK/COUNT, STATUS)
//   w_reset : registered system reset request
//   wd_irq  : warn_flag & IRQ_EN
module watchdog_ctrl
    import watchdog_ctrl_pkg::*;
#(
    parameter int               CNT_W          = 16,
    parameter int               PRESC_W        = 8,
    parameter int               RST_PULSE      = 4,
    parameter logic [CNT_W-1:0] DEFAULT_RELOAD = '1
) (
    input  logic            clk,
    input  logic            isReset,
    watchdog_ctrl_if.slave  bus,
    output logic            w_reset,
    output logic            wd_irq
);
    localparam int PC_W = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

    wd_state_e          state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d, reload_q, reload_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               en_q, en_d, irq_en_q, irq_en_d;
    logic               warn_q, warn_d, rstf_q, rstf_d;
    logic               wres_q, wres_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               warn_set, rst_set, presc_clr, tick, kick;
    logic               wr, wr_ctrl, wr_reload, wr_kick, wr_status;
    logic [BUS_W-1:0]   rd_data;
    logic               unused_dr;

    assign wr        = bus.isCS && bus.isW;
    assign wr_ctrl   = wr && (bus.addr == ADDR_CTRL);
    assign wr_reload = wr && (bus.addr == ADDR_RELOAD);
    assign wr_kick   = wr && (bus.addr == ADDR_KICK);
    assign wr_status = wr && (bus.addr == ADDR_STATUS);
    // Kicks are swallowed while the reset pulse is running.
    assign kick      = (wr_reload || wr_kick) && (state_q != ST_RST);
    assign unused_dr = ^bus.dR;

    // The pulse must complete regardless of EN, so the prescaler idles in RST.
    wd_prescaler #(.PRESC_W(PRESC_W)) u_presc (
        .clk     (clk),
        .isReset (isReset),
        .en      (en_q && (state_q != ST_RST)),
        .clr     (presc_clr),
        .presc   (presc_q),
        .tick    (tick)
    );

    always_comb begin
        en_d      = wr_ctrl ? bus.dR[CTRL_EN_BIT] : en_q;
        irq_en_d  = wr_ctrl ? bus.dR[CTRL_IRQ_EN_BIT] : irq_en_q;
        presc_d   = wr_ctrl ? bus.dR[CTRL_PRESC_LSB +: PRESC_W] : presc_q;
        reload_d  = wr_reload ? bus.dR[CNT_W-1:0] : reload_q;
        state_d   = state_q;
        count_d   = count_q;
        wres_d    = wres_q;
        pc_d      = pc_q;
        warn_set  = 1'b0;
        rst_set   = 1'b0;
        presc_clr = 1'b0;
        case (state_q)
            ST_RST: begin
                pc_d = pc_q + 1'b1;
                if (pc_q == PC_W'(RST_PULSE - 1)) begin
                    wres_d    = 1'b0;
                    state_d   = ST_RUN;
                    count_d   = reload_d;
                    presc_clr = 1'b1;
                end
            end
            default: begin
                if (kick) begin
                    state_d   = ST_RUN;
                    count_d   = reload_d;
                    presc_clr = 1'b1;
                end else if (tick) begin
                    if (count_q != '0) begin
                        count_d = count_q - 1'b1;
                    end else if (state_q == ST_RUN) begin
                        state_d  = ST_WARN;
                        count_d  = reload_d;
                        warn_set = 1'b1;
                    end else begin
                        state_d = ST_RST;
                        wres_d  = 1'b1;
                        pc_d    = '0;
                        rst_set = 1'b1;
                    end
                end
            end
        endcase
        // Write-1-to-clear; a set on the same edge wins.
        warn_d = (warn_q & ~(wr_status & bus.dR[STAT_WARN_BIT])) | warn_set;
        rstf_d = (rstf_q & ~(wr_status & bus.dR[STAT_RST_BIT]))  | rst_set;
    end

    always_ff @(negedge clk) begin
        if (isReset) begin
            state_q  <= ST_RUN;
            count_q  <= DEFAULT_RELOAD;
            reload_q <= DEFAULT_RELOAD;
            presc_q  <= '0;
            en_q     <= 1'b1;
            irq_en_q <= 1'b0;
            warn_q   <= 1'b0;
            rstf_q   <= 1'b0;
            wres_q   <= 1'b0;
            pc_q     <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            presc_q  <= presc_d;
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            warn_q   <= warn_d;
            rstf_q   <= rstf_d;
            wres_q   <= wres_d;
            pc_q     <= pc_d;
        end
    end

    always_comb begin
        rd_data = '0;
        if (bus.isCS && !bus.isW) begin
            case (bus.addr)
                ADDR_CTRL: begin
                    rd_data[CTRL_PRESC_LSB +: PRESC_W] = presc_q;
                    rd_data[CTRL_IRQ_EN_BIT]           = irq_en_q;
                    rd_data[CTRL_EN_BIT]               = en_q;
                end
                ADDR_RELOAD: rd_data[CNT_W-1:0] = reload_q;
                ADDR_KICK:   rd_data[CNT_W-1:0] = count_q;
                default: begin
                    rd_data[STAT_WARN_BIT] = warn_q;
                    rd_data[STAT_RST_BIT]  = rstf_q;
                end
            endcase
        end
    end

    assign bus.dW  = rd_data;
    assign w_reset = wres_q;
    assign wd_irq  = warn_q & irq_en_q;
endmodule
